// File: rtl/trap_request_arbiter_pkg.sv
// Shared definitions for the trap request arbiter: FSM state encoding,
// default machine-interrupt cause values and CSR bit positions.
package trap_request_arbiter_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ACK = 2'd1,
      ST_IN_TRAP  = 2'd2
   } state_t;

   // Default mcause values for machine-level interrupts (interrupt bit set)
   localparam logic [31:0] CAUSE_MSI_DEFAULT = 32'h8000_0003;
   localparam logic [31:0] CAUSE_MTI_DEFAULT = 32'h8000_0007;
   localparam logic [31:0] CAUSE_MEI_DEFAULT = 32'h8000_000B;

   // Enable bit positions in mie and mstatus
   localparam int MIE_MSI_BIT     = 3;
   localparam int MIE_MTI_BIT     = 7;
   localparam int MIE_MEI_BIT     = 11;
   localparam int MSTATUS_MIE_BIT = 3;

   // Width of the synchronous exception code from the pipeline
   localparam int EXC_CODE_W = 5;

endpackage

// File: rtl/trap_request_arbiter_irq_synchronizer.sv
// Single-bit flop chain that brings one asynchronous interrupt line into the
// clk domain. STAGES is expected to be 2 or 3.
module irq_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the raw line through the chain; reset clears every stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
      end else begin
         // NOTE: non-blocking assignment so every stage samples its
         // predecessor's old value and the chain really is STAGES deep.
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/trap_request_arbiter.sv
// Trap request arbiter: prioritises synchronous exceptions over machine
// interrupts, registers one cause/PC pair for the exception handler, holds
// the request until the handler acknowledges, and stalls the pipeline until
// the handler has finished the trap.
module trap_request_arbiter
   import trap_request_arbiter_pkg::*;
#(
   parameter int             XLEN        = 32,
   parameter int             SYNC_STAGES = 2,
   parameter logic [XLEN-1:0] CAUSE_MSI  = XLEN'(CAUSE_MSI_DEFAULT),
   parameter logic [XLEN-1:0] CAUSE_MTI  = XLEN'(CAUSE_MTI_DEFAULT),
   parameter logic [XLEN-1:0] CAUSE_MEI  = XLEN'(CAUSE_MEI_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  exc_valid,
   input  logic [EXC_CODE_W-1:0] exc_code,
   input  logic [XLEN-1:0]       exc_pc,
   input  logic [XLEN-1:0]       irq_pc,
   input  logic                  irq_sw,
   input  logic                  irq_timer,
   input  logic                  irq_ext,
   input  logic                  mstatus_mie,
   input  logic [XLEN-1:0]       mie_csr,
   input  logic                  handling_flag,
   output logic                  exception,
   output logic [XLEN-1:0]       mcause_out,
   output logic [XLEN-1:0]       trap_pc_out,
   output logic                  trap_stall,
   output logic                  double_fault
);

   state_t          state;
   logic            sw_sync;
   logic            timer_sync;
   logic            ext_sync;
   logic [2:0]      pend;       // {MEI, MTI, MSI}
   logic [XLEN-1:0] irq_cause;

   irq_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_sw (
      .clk (clk),
      .rst (rst),
      .d   (irq_sw),
      .q   (sw_sync)
   );

   irq_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_timer (
      .clk (clk),
      .rst (rst),
      .d   (irq_timer),
      .q   (timer_sync)
   );

   irq_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_ext (
      .clk (clk),
      .rst (rst),
      .d   (irq_ext),
      .q   (ext_sync)
   );

   // Interrupts that are both individually and globally enabled
   assign pend = {ext_sync, timer_sync, sw_sync}
               & {mie_csr[MIE_MEI_BIT], mie_csr[MIE_MTI_BIT], mie_csr[MIE_MSI_BIT]}
               & {3{mstatus_mie}};

   // Fixed interrupt priority: MEI > MSI > MTI
   always_comb begin
      // NOTE: default first so every path assigns irq_cause and no latch
      // is inferred when no interrupt is pending.
      irq_cause = '0;
      if (pend[2]) begin
         irq_cause = CAUSE_MEI;
      end else if (pend[0]) begin
         irq_cause = CAUSE_MSI;
      end else if (pend[1]) begin
         irq_cause = CAUSE_MTI;
      end
   end

   // Trap FSM with registered request, cause, PC, stall and error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         exception    <= 1'b0;
         mcause_out   <= '0;
         trap_pc_out  <= '0;
         trap_stall   <= 1'b0;
         double_fault <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // A synchronous exception beats any interrupt; a losing
               // interrupt stays pending because its line is a level.
               if (exc_valid) begin
                  mcause_out  <= {{(XLEN-EXC_CODE_W){1'b0}}, exc_code};
                  trap_pc_out <= exc_pc;
                  exception   <= 1'b1;
                  trap_stall  <= 1'b1;
                  state       <= ST_WAIT_ACK;
               end else if (pend != 3'b000) begin
                  mcause_out  <= irq_cause;
                  trap_pc_out <= irq_pc;
                  exception   <= 1'b1;
                  trap_stall  <= 1'b1;
                  state       <= ST_WAIT_ACK;
               end
               // handling_flag here is a handler protocol error; ignored.
            end

            ST_WAIT_ACK: begin
               // Request, cause and PC stay put until the handler takes it
               if (exc_valid) begin
                  double_fault <= 1'b1;
               end
               if (handling_flag) begin
                  exception <= 1'b0;
                  state     <= ST_IN_TRAP;
               end
            end

            ST_IN_TRAP: begin
               // Nested exceptions cannot be serviced; flag and drop them
               if (exc_valid) begin
                  double_fault <= 1'b1;
               end
               // Returning to IDLE (not straight to a new request) forces at
               // least one exception=0 cycle between consecutive traps.
               if (!handling_flag) begin
                  trap_stall <= 1'b0;
                  state      <= ST_IDLE;
               end
            end

            default: begin
               exception  <= 1'b0;
               trap_stall <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
